// File: rtl/collision_score_if.sv
// Bundle of game-state signals between the pipeline and collision_score.
//   start      : single-cycle start pulse
//   birdY      : top y of the bird sprite
//   Ax, Ay     : right-side x and gap-centre y of column A
//   Bx, By     : right-side x and gap-centre y of column B
//   passColumn : one-cycle pulse when a column wraps
//   finished   : high in IDLE or DEAD
//   playing    : high in PLAY
//   hit        : one-cycle pulse when a collision ends play
//   score      : packed BCD current score
//   highScore  : packed BCD best score since reset
// The master modport drives the game inputs; the slave modport is the scorer.
interface collision_score_if;
  logic        start;
  logic [10:0] birdY;
  logic [10:0] Ax;
  logic [10:0] Ay;
  logic [10:0] Bx;
  logic [10:0] By;
  logic        passColumn;
  logic        finished;
  logic        playing;
  logic        hit;
  logic [15:0] score;
  logic [15:0] highScore;

  modport master (
    output start, birdY, Ax, Ay, Bx, By, passColumn,
    input  finished, playing, hit, score, highScore
  );

  modport slave (
    input  start, birdY, Ax, Ay, Bx, By, passColumn,
    output finished, playing, hit, score, highScore
  );
endinterface

// File: rtl/collision_score.sv
// Collision detection, game state FSM (IDLE/PLAY/DEAD) and BCD scoring.
//   gameClk : game tick clock, all state changes on its rising edge
//   reset   : asynchronous active-low reset
//   bus     : collision_score_if.slave carrying game inputs and status outputs
module collision_score #(
  parameter int unsigned ScreenHeight = 480,
  parameter int unsigned PipeW        = 40,
  parameter int unsigned GapHalf      = 60,
  parameter int unsigned BirdX        = 200,
  parameter int unsigned BirdSize     = 16
) (
  input  logic                gameClk,
  input  logic                reset,
  collision_score_if.slave    bus
);

  typedef enum logic [1:0] {StIdle, StPlay, StDead} state_e;

  localparam logic [11:0] XLo      = 12'(BirdX);
  localparam logic [11:0] XHi      = 12'(BirdX + BirdSize + PipeW - 2);
  localparam logic [11:0] GapHalfW = 12'(GapHalf);
  localparam logic [11:0] SizeW    = 12'(BirdSize);
  localparam logic [11:0] SizeM1W  = 12'(BirdSize - 1);
  localparam logic [11:0] FloorW   = 12'(ScreenHeight);

  state_e      state_q, state_d;
  logic [15:0] score_q, score_d;
  logic [15:0] high_q, high_d;
  logic        hit_q, hit_d;

  logic [11:0] bird_y;
  logic        pipe_hit, floor_hit, collide;

  // Column right edge inside the band where its span overlaps the bird's x span.
  function automatic logic x_hit(logic [10:0] x);
    logic [11:0] xw;
    xw = {1'b0, x};
    return (xw >= XLo) && (xw <= XHi);
  endfunction

  // Both bird edges inside the gap; written as additions so nothing underflows.
  function automatic logic gap_ok(logic [11:0] by, logic [10:0] y);
    logic [11:0] yw;
    yw = {1'b0, y};
    return (by + GapHalfW >= yw) && (by + SizeM1W <= yw + GapHalfW);
  endfunction

  // Digit-wise BCD increment, ripple carry from the least significant digit.
  function automatic logic [15:0] bcd_inc(logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign bird_y    = {1'b0, bus.birdY};
  assign pipe_hit  = (x_hit(bus.Ax) && !gap_ok(bird_y, bus.Ay)) ||
                     (x_hit(bus.Bx) && !gap_ok(bird_y, bus.By));
  assign floor_hit = (bird_y + SizeW >= FloorW);
  assign collide   = pipe_hit || floor_hit;

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    high_d  = high_q;
    hit_d   = 1'b0;
    unique case (state_q)
      StIdle, StDead: begin
        if (bus.start) begin
          state_d = StPlay;
          score_d = 16'h0000;
        end
      end
      StPlay: begin
        if (collide) begin
          state_d = StDead;
          hit_d   = 1'b1;
          if (score_q > high_q) begin
            high_d = score_q;
          end
        end else if (bus.passColumn && (score_q != 16'h9999)) begin
          score_d = bcd_inc(score_q);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge gameClk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      score_q <= 16'h0000;
      high_q  <= 16'h0000;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      high_q  <= high_d;
      hit_q   <= hit_d;
    end
  end

  assign bus.finished  = (state_q != StPlay);
  assign bus.playing   = (state_q == StPlay);
  assign bus.hit       = hit_q;
  assign bus.score     = score_q;
  assign bus.highScore = high_q;

endmodule

// File: tb/tb_collision_score.sv
module tb_collision_score;

  logic gameClk;
  logic reset;
  int   checks;
  int   errors;

  collision_score_if bus ();

  collision_score dut (
    .gameClk (gameClk),
    .reset   (reset),
    .bus     (bus.slave)
  );

  initial gameClk = 1'b0;
  always #5 gameClk = ~gameClk;

  typedef struct {
    logic        start;
    logic [10:0] birdY;
    logic [10:0] ax;
    logic [10:0] ay;
    logic [10:0] bx;
    logic [10:0] by;
    logic        pass;
    logic        e_fin;
    logic        e_play;
    logic        e_hit;
    logic [15:0] e_score;
    logic [15:0] e_high;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic fin, input logic play, input logic hit,
                         input logic [15:0] sc, input logic [15:0] hs);
    chk({name, ".finished"},  {31'd0, bus.finished}, {31'd0, fin});
    chk({name, ".playing"},   {31'd0, bus.playing},  {31'd0, play});
    chk({name, ".hit"},       {31'd0, bus.hit},      {31'd0, hit});
    chk({name, ".score"},     {16'd0, bus.score},    {16'd0, sc});
    chk({name, ".highScore"}, {16'd0, bus.highScore}, {16'd0, hs});
  endtask

  task automatic step();
    @(posedge gameClk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [10:0] y, input logic [10:0] ax,
                       input logic [10:0] ay, input logic [10:0] bx, input logic [10:0] by,
                       input logic ps);
    bus.start      = st;
    bus.birdY      = y;
    bus.Ax         = ax;
    bus.Ay         = ay;
    bus.Bx         = bx;
    bus.By         = by;
    bus.passColumn = ps;
  endtask

  // Safe bird in column A's gap, column B far away.
  task automatic safe(input logic st, input logic ps);
    drive(st, 11'd200, 11'd230, 11'd240, 11'd600, 11'd240, ps);
  endtask

  task automatic crash();
    drive(1'b0, 11'd170, 11'd230, 11'd240, 11'd600, 11'd240, 1'b0);
  endtask

  task automatic passes(input int n);
    safe(1'b0, 1'b1);
    repeat (n) step();
    safe(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    safe(1'b0, 1'b0);
    #2 reset = 1'b0;
    #13 reset = 1'b1;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    //            st  birdY   Ax     Ay     Bx     By   ps  fin ply hit score    high
    vecs[0]  = '{1'b1, 11'd200, 11'd230, 11'd240, 11'd600, 11'd240, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 11'd200, 11'd230, 11'd240, 11'd600, 11'd240, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b0, 11'd200, 11'd230, 11'd240, 11'd600, 11'd240, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0001, 16'h0000};
    vecs[3]  = '{1'b0, 11'd170, 11'd230, 11'd240, 11'd600, 11'd240, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0001, 16'h0001};
    vecs[4]  = '{1'b0, 11'd200, 11'd230, 11'd240, 11'd600, 11'd240, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 16'h0001};
    vecs[5]  = '{1'b0, 11'd200, 11'd230, 11'd240, 11'd600, 11'd240, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 16'h0001};
    vecs[6]  = '{1'b1, 11'd170, 11'd230, 11'd240, 11'd600, 11'd240, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0001};
    vecs[7]  = '{1'b0, 11'd464, 11'd600, 11'd240, 11'd100, 11'd240, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0001};
    vecs[8]  = '{1'b1, 11'd463, 11'd600, 11'd240, 11'd100, 11'd240, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0001};
    vecs[9]  = '{1'b0, 11'd463, 11'd600, 11'd240, 11'd100, 11'd240, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0001, 16'h0001};
    vecs[10] = '{1'b1, 11'd0,   11'd600, 11'd240, 11'd100, 11'd240, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0002, 16'h0001};
    vecs[11] = '{1'b0, 11'd170, 11'd230, 11'd240, 11'd600, 11'd240, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0002, 16'h0002};
    vecs[12] = '{1'b1, 11'd200, 11'd230, 11'd240, 11'd600, 11'd240, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0002};
    vecs[13] = '{1'b0, 11'd170, 11'd255, 11'd240, 11'd199, 11'd240, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0001, 16'h0002};
    vecs[14] = '{1'b0, 11'd285, 11'd600, 11'd240, 11'd254, 11'd240, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0002, 16'h0002};
    vecs[15] = '{1'b0, 11'd286, 11'd600, 11'd240, 11'd254, 11'd240, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0002, 16'h0002};
    vecs[16] = '{1'b0, 11'd200, 11'd230, 11'd240, 11'd600, 11'd240, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 16'h0002};

    do_reset();
    chk_all("reset", 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].start, vecs[i].birdY, vecs[i].ax, vecs[i].ay, vecs[i].bx, vecs[i].by,
            vecs[i].pass);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_fin, vecs[i].e_play, vecs[i].e_hit,
              vecs[i].e_score, vecs[i].e_high);
    end

    // High score tracking across two games.
    do_reset();
    safe(1'b1, 1'b0);
    step();
    passes(12);
    chk("score12", {16'd0, bus.score}, 32'h0012);
    crash();
    step();
    chk_all("die12", 1'b1, 1'b0, 1'b1, 16'h0012, 16'h0012);
    safe(1'b1, 1'b0);
    step();
    passes(5);
    crash();
    step();
    chk_all("die5", 1'b1, 1'b0, 1'b1, 16'h0005, 16'h0012);

    // BCD carries and saturation.
    safe(1'b1, 1'b0);
    step();
    passes(9);
    chk("score9", {16'd0, bus.score}, 32'h0009);
    passes(1);
    chk("score10", {16'd0, bus.score}, 32'h0010);
    passes(89);
    chk("score99", {16'd0, bus.score}, 32'h0099);
    passes(1);
    chk("score100", {16'd0, bus.score}, 32'h0100);
    passes(9899);
    chk("score9999", {16'd0, bus.score}, 32'h9999);
    passes(1);
    chk("score_sat", {16'd0, bus.score}, 32'h9999);
    crash();
    step();
    chk_all("die9999", 1'b1, 1'b0, 1'b1, 16'h9999, 16'h9999);

    // Asynchronous reset mid-PLAY.
    do_reset();
    safe(1'b1, 1'b0);
    step();
    passes(7);
    chk_all("pre_rst", 1'b0, 1'b1, 1'b0, 16'h0007, 16'h0000);
    #2 reset = 1'b0;
    #1;
    chk_all("async_rst", 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    #3 reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
